// File: rtl/debug_pkg.sv
// Shared definitions for the debug memory master: opcodes, FSM state encoding and sizes.
package debug_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [BYTE_W-1:0] DBG_WR_IRAM = 8'h01;
  localparam logic [BYTE_W-1:0] DBG_RD_IRAM = 8'h02;
  localparam logic [BYTE_W-1:0] DBG_WR_DRAM = 8'h03;
  localparam logic [BYTE_W-1:0] DBG_RD_DRAM = 8'h04;
  localparam logic [BYTE_W-1:0] DBG_HOLD    = 8'h10;
  localparam logic [BYTE_W-1:0] DBG_RELEASE = 8'h11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } dbg_state_e;

  // Memory opcodes carry an address phase; hold/release do not.
  function automatic logic is_mem_op(input logic [BYTE_W-1:0] op);
    return (op == DBG_WR_IRAM) || (op == DBG_RD_IRAM) ||
           (op == DBG_WR_DRAM) || (op == DBG_RD_DRAM);
  endfunction

endpackage

// File: rtl/dbg_tx_serializer.sv
// Sends a loaded 32-bit word as 4 bytes LSB-first over a valid/ready stream.
module dbg_tx_serializer
  import debug_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              tx_ready_i,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              done_c_o
);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic              valid_q, valid_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              fire;

  always_comb begin
    sh_d     = sh_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    fire     = valid_q && tx_ready_i;
    done_c_o = fire && (cnt_q == 2'(WORD_BYTES - 1));
    if (load_i) begin
      sh_d    = word_i;
      valid_d = 1'b1;
      cnt_d   = 2'd0;
    end else if (fire) begin
      sh_d  = {8'h00, sh_q[WORD_W-1:BYTE_W]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'(WORD_BYTES - 1)) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      sh_q    <= sh_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_data_o  = sh_q[BYTE_W-1:0];
  assign tx_valid_o = valid_q;

endmodule

// File: rtl/debug_mem_master.sv
// Host byte-stream to debug RAM port bridge: decodes command frames, drives A2/WD2/WE2
// of the instruction and data RAMs and streams read words back as bytes.
module debug_mem_master
  import debug_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic [BYTE_W-1:0] RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic [BYTE_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic [WORD_W-1:0] InstRAM_A2,
  output logic [WORD_W-1:0] DataRAM_A2,
  output logic [WORD_W-1:0] InstRAM_WD2,
  output logic [WORD_W-1:0] DataRAM_WD2,
  output logic [3:0]        InstRAM_WE2,
  output logic [3:0]        DataRAM_WE2,
  input  logic [WORD_W-1:0] InstRAM_RD2,
  input  logic [WORD_W-1:0] DataRAM_RD2,
  output logic              CoreHold,
  output logic              Busy,
  output logic              CmdErr
);

  dbg_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wd_q, wd_d;
  logic              is_wr_q, is_wr_d;
  logic              sel_dram_q, sel_dram_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic [3:0]        iwe_q, iwe_d;
  logic [3:0]        dwe_q, dwe_d;
  logic              rx_fire;
  logic              ser_load_c;
  logic              ser_done_c;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] rx_shift;

  assign rx_fire  = RxValid && rx_ready_q;
  assign rx_shift = {RxData, sh_q[WORD_W-1:BYTE_W]};
  assign rd_word  = sel_dram_q ? DataRAM_RD2 : InstRAM_RD2;

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    is_wr_d    = is_wr_q;
    sel_dram_d = sel_dram_q;
    hold_d     = hold_q;
    err_d      = 1'b0;
    ser_load_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (is_mem_op(RxData)) begin
            state_d    = ST_ADDR;
            cnt_d      = 2'd0;
            is_wr_d    = (RxData == DBG_WR_IRAM) || (RxData == DBG_WR_DRAM);
            sel_dram_d = (RxData == DBG_WR_DRAM) || (RxData == DBG_RD_DRAM);
          end else if (RxData == DBG_HOLD) begin
            hold_d = 1'b1;
          end else if (RxData == DBG_RELEASE) begin
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          sh_d  = rx_shift;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(WORD_BYTES - 1)) begin
            addr_d  = {rx_shift[WORD_W-1:2], 2'b00};
            cnt_d   = 2'd0;
            state_d = is_wr_q ? ST_DATA : ST_RD_WAIT;
          end
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          sh_d  = rx_shift;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(WORD_BYTES - 1)) begin
            wd_d    = rx_shift;
            cnt_d   = 2'd0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        // A2 is stable here; capture the selected RD2 on the final wait cycle.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(RD_LATENCY - 1)) begin
          ser_load_c = 1'b1;
          cnt_d      = 2'd0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (ser_done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    busy_d     = (state_d != ST_IDLE);
    iwe_d      = ((state_d == ST_WRITE) && !sel_dram_d) ? 4'hF : 4'h0;
    dwe_d      = ((state_d == ST_WRITE) &&  sel_dram_d) ? 4'hF : 4'h0;
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      sh_q       <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      is_wr_q    <= 1'b0;
      sel_dram_q <= 1'b0;
      hold_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      iwe_q      <= 4'h0;
      dwe_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      is_wr_q    <= is_wr_d;
      sel_dram_q <= sel_dram_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      iwe_q      <= iwe_d;
      dwe_q      <= dwe_d;
    end
  end

  dbg_tx_serializer u_ser (
    .clk_i      (CPU_CLK),
    .rst_i      (CPU_RST),
    .load_i     (ser_load_c),
    .word_i     (rd_word),
    .tx_ready_i (TxReady),
    .tx_data_o  (TxData),
    .tx_valid_o (TxValid),
    .done_c_o   (ser_done_c)
  );

  assign RxReady     = rx_ready_q;
  assign InstRAM_A2  = addr_q;
  assign DataRAM_A2  = addr_q;
  assign InstRAM_WD2 = wd_q;
  assign DataRAM_WD2 = wd_q;
  assign InstRAM_WE2 = iwe_q;
  assign DataRAM_WE2 = dwe_q;
  assign CoreHold    = hold_q;
  assign Busy        = busy_q;
  assign CmdErr      = err_q;

endmodule
